vehicle_sensor_conditioner: RTL and testbench

Conditions the raw inductive-loop detector inputs for the main and side roads and produces the `main_road_sensor` / `side_road_sensor` request levels consumed by `traffic_light_controller`. Sits directly upstream of the controller. It does four things:
- synchronises and debounces each loop;
- latches a waiting-vehicle request until that road's light turns green (light outputs fed back from the controller);
- counts arrivals;
- flags stuck detectors.

---
 rtl/vehicle_sensor_conditioner_if.sv | 46 ++++
 rtl/vehicle_sensor_conditioner.sv | 159 +++++++++++++++
 tb/tb_vehicle_sensor_conditioner.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vehicle_sensor_conditioner_if.sv
// rtl/vehicle_sensor_conditioner_if.sv - loop detector inputs, light feedback and conditioned outputs
// master drives the raw loops and light feedback; slave is the conditioner.

interface vehicle_sensor_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             main_loop_raw;
    logic             side_loop_raw;
    logic [1:0]       main_road_light;
    logic [1:0]       side_road_light;
    logic             count_clear;
    logic             main_road_sensor;
    logic             side_road_sensor;
    logic [CNT_W-1:0] main_vehicle_count;
    logic [CNT_W-1:0] side_vehicle_count;
    logic             main_stuck;
    logic             side_stuck;

    modport master (
        output main_loop_raw,
        output side_loop_raw,
        output main_road_light,
        output side_road_light,
        output count_clear,
        input  main_road_sensor,
        input  side_road_sensor,
        input  main_vehicle_count,
        input  side_vehicle_count,
        input  main_stuck,
        input  side_stuck
    );

    modport slave (
        input  main_loop_raw,
        input  side_loop_raw,
        input  main_road_light,
        input  side_road_light,
        input  count_clear,
        output main_road_sensor,
        output side_road_sensor,
        output main_vehicle_count,
        output side_vehicle_count,
        output main_stuck,
        output side_stuck
    );
endinterface

// File: rtl/vehicle_sensor_conditioner.sv
// rtl/vehicle_sensor_conditioner.sv - loop detector sync, debounce, request latch, arrival count, stuck flag
// One channel module per road; the top wires two identical channels to the interface.

module vehicle_sensor_conditioner_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw,
    input  logic [1:0]       light,
    input  logic             count_clear,
    output logic             sensor,
    output logic [CNT_W-1:0] count,
    output logic             stuck
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(STUCK_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          deb;
    logic          deb_d;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          req;
    logic          green;
    logic          deb_rise;

    assign green    = (light == 2'b10);
    assign deb_rise = deb & ~deb_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Any bounce back to the current level restarts the stability count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb  <= 1'b0;
            dcnt <= '0;
        end else if (s2 == deb) begin
            dcnt <= '0;
        end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb  <= s2;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt <= '0;
        end else if (!deb) begin
            hcnt <= '0;
        end else if (hcnt != HW'(STUCK_CYCLES)) begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stuck <= 1'b0;
        end else begin
            stuck <= (hcnt == HW'(STUCK_CYCLES - 1)) | (stuck & deb);
        end
    end

    // Green clears with priority; a stuck loop cannot raise a new request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req <= 1'b0;
        end else begin
            req <= (req | (deb & ~stuck)) & ~green;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (count_clear) begin
            count <= '0;
        end else if (deb_rise && !(&count)) begin
            count <= count + 1'b1;
        end
    end

    assign sensor = req;
endmodule

module vehicle_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1000,
    parameter int CNT_W           = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    vehicle_sensor_conditioner_if.slave   bus
);
    logic             main_sensor;
    logic             side_sensor;
    logic [CNT_W-1:0] main_count;
    logic [CNT_W-1:0] side_count;
    logic             main_stuck_flag;
    logic             side_stuck_flag;

    vehicle_sensor_conditioner_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) main_channel (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (bus.main_loop_raw),
        .light       (bus.main_road_light),
        .count_clear (bus.count_clear),
        .sensor      (main_sensor),
        .count       (main_count),
        .stuck       (main_stuck_flag)
    );

    vehicle_sensor_conditioner_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES),
        .CNT_W           (CNT_W)
    ) side_channel (
        .clk         (clk),
        .reset_n     (reset_n),
        .raw         (bus.side_loop_raw),
        .light       (bus.side_road_light),
        .count_clear (bus.count_clear),
        .sensor      (side_sensor),
        .count       (side_count),
        .stuck       (side_stuck_flag)
    );

    assign bus.main_road_sensor   = main_sensor;
    assign bus.side_road_sensor   = side_sensor;
    assign bus.main_vehicle_count = main_count;
    assign bus.side_vehicle_count = side_count;
    assign bus.main_stuck         = main_stuck_flag;
    assign bus.side_stuck         = side_stuck_flag;
endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// tb/tb_vehicle_sensor_conditioner.sv - directed vectors for vehicle_sensor_conditioner
// Edge 0 is the first clock edge that samples a newly driven raw level.

module tb_vehicle_sensor_conditioner;
    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    vehicle_sensor_conditioner_if #(.CNT_W(3)) bus ();

    vehicle_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .STUCK_CYCLES    (50),
        .CNT_W           (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n             = 1'b0;
        bus.main_loop_raw   = 1'b0;
        bus.side_loop_raw   = 1'b1;
        bus.main_road_light = 2'b10;
        bus.side_road_light = 2'b00;
        bus.count_clear     = 1'b0;

        // Reset with the side loop held high
        tick(3);
        check("rst_main_sensor", {31'd0, bus.main_road_sensor}, 32'd0);
        check("rst_side_sensor", {31'd0, bus.side_road_sensor}, 32'd0);
        check("rst_main_count", {29'd0, bus.main_vehicle_count}, 32'd0);
        check("rst_side_count", {29'd0, bus.side_vehicle_count}, 32'd0);
        check("rst_main_stuck", {31'd0, bus.main_stuck}, 32'd0);
        check("rst_side_stuck", {31'd0, bus.side_stuck}, 32'd0);
        reset_n = 1'b1;
        tick(6);
        check("rel_sensor_edge5", {31'd0, bus.side_road_sensor}, 32'd0);
        tick(1);
        check("rel_sensor_edge6", {31'd0, bus.side_road_sensor}, 32'd1);
        check("rel_count", {29'd0, bus.side_vehicle_count}, 32'd1);

        // Glitch rejection: 3-cycle pulse, then a 4-cycle pulse
        bus.side_loop_raw = 1'b0;
        do_reset();
        tick(4);
        bus.side_loop_raw = 1'b1;
        tick(3);
        bus.side_loop_raw = 1'b0;
        tick(12);
        check("glitch3_sensor", {31'd0, bus.side_road_sensor}, 32'd0);
        check("glitch3_count", {29'd0, bus.side_vehicle_count}, 32'd0);
        bus.side_loop_raw = 1'b1;
        tick(4);
        bus.side_loop_raw = 1'b0;
        tick(2);
        check("pulse4_sensor_edge5", {31'd0, bus.side_road_sensor}, 32'd0);
        tick(1);
        check("pulse4_sensor_edge6", {31'd0, bus.side_road_sensor}, 32'd1);
        check("pulse4_count", {29'd0, bus.side_vehicle_count}, 32'd1);

        // Latch and service
        do_reset();
        bus.side_loop_raw = 1'b1;
        tick(10);
        bus.side_loop_raw = 1'b0;
        tick(12);
        check("latch_hold", {31'd0, bus.side_road_sensor}, 32'd1);
        bus.side_road_light = 2'b10;
        tick(1);
        check("latch_green_clear", {31'd0, bus.side_road_sensor}, 32'd0);
        bus.side_road_light = 2'b00;
        tick(3);
        check("latch_after_green", {31'd0, bus.side_road_sensor}, 32'd0);

        // Vehicle present through green on main road
        do_reset();
        bus.main_road_light = 2'b10;
        bus.main_loop_raw   = 1'b1;
        tick(10);
        check("present_green", {31'd0, bus.main_road_sensor}, 32'd0);
        bus.main_road_light = 2'b01;
        tick(1);
        check("present_yellow", {31'd0, bus.main_road_sensor}, 32'd1);
        bus.main_road_light = 2'b10;
        tick(1);
        check("present_green_again", {31'd0, bus.main_road_sensor}, 32'd0);
        bus.main_road_light = 2'b11;
        tick(1);
        check("present_light_11", {31'd0, bus.main_road_sensor}, 32'd1);
        bus.main_road_light = 2'b10;
        tick(1);
        check("present_green_third", {31'd0, bus.main_road_sensor}, 32'd0);
        check("present_count", {29'd0, bus.main_vehicle_count}, 32'd1);
        bus.main_loop_raw = 1'b0;

        // Stuck side loop: deb rises at edge 5, stuck at edge 55
        do_reset();
        bus.side_road_light = 2'b10;
        bus.side_loop_raw   = 1'b1;
        tick(55);
        check("stuck_edge54", {31'd0, bus.side_stuck}, 32'd0);
        tick(1);
        check("stuck_edge55", {31'd0, bus.side_stuck}, 32'd1);
        check("stuck_sensor_green", {31'd0, bus.side_road_sensor}, 32'd0);
        bus.side_road_light = 2'b00;
        tick(3);
        check("stuck_sensor_red", {31'd0, bus.side_road_sensor}, 32'd0);
        tick(1);
        bus.side_loop_raw = 1'b0;
        tick(6);
        check("unstuck_edge5", {31'd0, bus.side_stuck}, 32'd1);
        tick(1);
        check("unstuck_edge6", {31'd0, bus.side_stuck}, 32'd0);
        check("unstuck_sensor", {31'd0, bus.side_road_sensor}, 32'd0);
        check("main_never_stuck", {31'd0, bus.main_stuck}, 32'd0);

        // Saturating 3-bit counter and clear priority
        do_reset();
        bus.side_road_light = 2'b10;
        for (int i = 1; i <= 9; i++) begin
            bus.side_loop_raw = 1'b1;
            tick(8);
            bus.side_loop_raw = 1'b0;
            tick(8);
            check($sformatf("cnt_pulse%0d", i), {29'd0, bus.side_vehicle_count},
                  (i < 7) ? i : 7);
        end
        bus.side_loop_raw = 1'b1;
        tick(6);
        check("cnt_before_clear", {29'd0, bus.side_vehicle_count}, 32'd7);
        bus.count_clear = 1'b1;
        tick(1);
        bus.count_clear = 1'b0;
        check("cnt_clear_vs_rise", {29'd0, bus.side_vehicle_count}, 32'd0);
        tick(1);
        bus.side_loop_raw = 1'b0;
        tick(8);
        check("cnt_clear_hold", {29'd0, bus.side_vehicle_count}, 32'd0);
        bus.side_loop_raw = 1'b1;
        tick(8);
        bus.side_loop_raw = 1'b0;
        tick(8);
        check("cnt_after_clear", {29'd0, bus.side_vehicle_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
